taxi_xgmii_baser_enc_64: RTL and testbench
==========================================

// Module: taxi_xgmii_baser_enc_64
// PURPOSE
//  XGMII-to-10GBASE-R 64b/66b block encoder, 64-bit datapath. It is the TX counterpart of the 10GBASE-R RX decoder.
//  Sits between the MAC XGMII TX output and the TX scrambler/gearbox. Maps each 8-lane XGMII word to a 2-bit sync header and a 64-bit block.
//  Flags unencodable words and start/terminate sequence violations.
// PARAMETERS
//  DATA_W     64    XGMII/block data width; elaboration $fatal if not 64
//  CTRL_W     8     DATA_W/8 lanes; $fatal if CTRL_W*8 != DATA_W
//  HDR_W      2     sync header width; $fatal if not 2
//  GBX_IF_EN  1'b0  1: honour xgmii_tx_valid and drive the output valids; 0: valids tied 1
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   synchronous, active-high reset
//  xgmii_txd              in   64  XGMII data, lane i = [8i+7:8i]
//  xgmii_txc              in   8   XGMII control, bit i set = lane i is a control character
//  xgmii_tx_valid         in   1   input word valid (GBX_IF_EN only; default 1)
//  encoded_tx_data        out  64  66b block payload, block type in [7:0]
//  encoded_tx_data_valid  out  1   payload valid (GBX_IF_EN ? reg : 1)
//  encoded_tx_hdr         out  2   sync header: 2'b10 data, 2'b01 control
//  encoded_tx_hdr_valid   out  1   header valid (GBX_IF_EN ? reg : 1)
//  tx_bad_block           out  1   1-cycle pulse: input not encodable, error block emitted
//  tx_sequence_error      out  1   1-cycle pulse: Start while in frame, or Terminate while not in frame
// BEHAVIOUR
//  - Latency: fully registered, exactly 1 clk from input to all outputs; no backpressure.
//  - Reset: data=64'h1e, hdr=2'b01 (all-idle control block); valid regs=0; tx_bad_block=0; tx_sequence_error=0; frame=0.
//  - Lane control code map (7-bit): 07->00, 06->06, fe->1e, 1c->2d, 3c->33, 7c->4b, bc->55, dc->66, f7->78.
//    Any other control char is a lane error.
//  - Control code for lane i always sits at bits [7i+8 +: 7]. All unused/pad bits are 0. O-code for Seq OS (9c) = 4'h0.
//  - txc==00: hdr 10, data = txd verbatim.
//  - All other words: hdr 01. Block type selected by txc pattern + key characters:
//      ff, all lanes mapped          BT 1e; C0..C7
//      01, lane0=fb                  BT 78; D1..D7 in [63:8]
//      1f, lane4=fb, lanes0-3 mapped BT 33; C0..C3, pad [39:36], D5..D7 in [63:40]
//      11, lane0=9c, lane4=fb        BT 66; D1..D3 [31:8], O0 [35:32], D5..D7 [63:40]
//      11, lane0=9c, lane4=9c        BT 55; D1..D3, O0 [35:32], O4 [39:36], D5..D7
//      f1, lane0=9c, lanes4-7 mapped BT 4b; D1..D3, O0 [35:32], C4..C7
//      1f, lane4=9c, lanes0-3 mapped BT 2d; C0..C3, O4 [39:36], D5..D7
//      lane k=fd, txc = ~((1<<k)-1), lanes>k mapped: BT 87,99,aa,b4,cc,d2,e1,ff for k=0..7
//        D0..Dk-1 in [8k+7:8] (exactly k data bytes), C(k+1)..C7 at their lane positions
//  - Anything else (unmatched pattern, unmapped lane, fb/fd/9c in a wrong lane):
//    hdr 01, data = {8{7'h1e}, 8'h1e}, tx_bad_block=1. frame unchanged.
//  - Frame tracking: the encoded Start blocks 78/33/66 set frame; tx_sequence_error=frame(old).
//    Terminate blocks clear frame; tx_sequence_error=!frame(old).
//    Sequence errors are flagged only; the block is still encoded normally.
//  - GBX_IF_EN=1 and xgmii_tx_valid=0: valid regs=0, data/hdr hold previous value, status=0, frame held.
//  - GBX_IF_EN=0: xgmii_tx_valid ignored; both valid outputs constant 1.
//  - Reset mid-frame: frame cleared; the next Terminate raises tx_sequence_error.
// TESTING
//  - Reset, then txd=0707..07, txc=ff -> next cycle hdr 01, data 64'h0000_0000_0000_001e, bad=0.
//  - txd=d5555555555555fb, txc=01 -> hdr 01, data 64'hd555_5555_5555_5578.
//    Then txd=0123456789abcdef, txc=00 -> hdr 10, data verbatim.
//  - Terminate in lane 3: txd=070707fd_aabbcc, txc=f8 (lane3=fd, bytes cc,bb,aa) -> BT b4.
//    Expect [31:8]=aabbcc, bits 35:32 = 0, C4..C7 = 0, sequence error 0.
//  - txc=ff with lane2=0x55 -> error block {8{7'h1e},8'h1e}, tx_bad_block=1 for 1 cycle.
//  - Two consecutive Start blocks -> second raises tx_sequence_error. Term with no frame -> raises it.
//    Test rst between Start and Term.
//  - GBX_IF_EN=1: toggle xgmii_tx_valid 1,0,1 -> output valids 1,0,1 one cycle later; data held while invalid.

Source files
------------

// File: rtl/taxi_xgmii_baser_enc_64.sv
// XGMII to 10GBASE-R 64b/66b block encoder with a 64-bit datapath.
// It tracks frame state so that misplaced Start and Terminate blocks can be flagged.
module taxi_xgmii_baser_enc_64 #(
  parameter int   DATA_W    = 64,
  parameter int   CTRL_W    = (DATA_W/8),
  parameter int   HDR_W     = 2,
  parameter logic GBX_IF_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] xgmii_txd,
  input  logic [CTRL_W-1:0] xgmii_txc,
  input  logic              xgmii_tx_valid,
  output logic [DATA_W-1:0] encoded_tx_data,
  output logic              encoded_tx_data_valid,
  output logic [HDR_W-1:0]  encoded_tx_hdr,
  output logic              encoded_tx_hdr_valid,
  output logic              tx_bad_block,
  output logic              tx_sequence_error
);

  if (DATA_W != 64) begin : g_badDataW
    $fatal(1, "DATA_W must be 64");
  end
  if (CTRL_W * 8 != DATA_W) begin : g_badCtrlW
    $fatal(1, "CTRL_W*8 must equal DATA_W");
  end
  if (HDR_W != 2) begin : g_badHdrW
    $fatal(1, "HDR_W must be 2");
  end

  localparam logic [1:0]  HDR_DATA  = 2'b10;
  localparam logic [1:0]  HDR_CTRL  = 2'b01;
  localparam logic [3:0]  O_SEQ     = 4'h0;
  localparam logic [63:0] ERR_BLOCK = {{8{7'h1e}}, 8'h1e};
  localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // Bit 7 of the result says whether the character is encodable; bits 6:0 hold the 7-bit code.
  function automatic logic [7:0] mapCtrl(input logic [7:0] c);
    case (c)
      8'h07:   mapCtrl = {1'b1, 7'h00};
      8'h06:   mapCtrl = {1'b1, 7'h06};
      8'hfe:   mapCtrl = {1'b1, 7'h1e};
      8'h1c:   mapCtrl = {1'b1, 7'h2d};
      8'h3c:   mapCtrl = {1'b1, 7'h33};
      8'h7c:   mapCtrl = {1'b1, 7'h4b};
      8'hbc:   mapCtrl = {1'b1, 7'h55};
      8'hdc:   mapCtrl = {1'b1, 7'h66};
      8'hf7:   mapCtrl = {1'b1, 7'h78};
      default: mapCtrl = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] termType(input int k);
    case (k)
      0:       termType = 8'h87;
      1:       termType = 8'h99;
      2:       termType = 8'haa;
      3:       termType = 8'hb4;
      4:       termType = 8'hcc;
      5:       termType = 8'hd2;
      6:       termType = 8'he1;
      default: termType = 8'hff;
    endcase
  endfunction

  logic [7:0]  w_lane [8];
  logic [6:0]  w_cc [8];
  logic [7:0]  w_mapped;
  logic [7:0]  w_gtMask;
  logic [63:0] w_encData;
  logic [1:0]  w_encHdr;
  logic        w_bad;
  logic        w_isStart;
  logic        w_isTerm;
  logic        w_seqErr;
  logic        w_accept;
  state_t      r_state;
  state_t      w_nextState;

  logic [63:0] r_data;
  logic [1:0]  r_hdr;
  logic        r_dataValid;
  logic        r_hdrValid;
  logic        r_bad;
  logic        r_seqErr;

  assign w_accept = !GBX_IF_EN || xgmii_tx_valid;

  always_comb begin
    w_mapped = '0;
    for (int i = 0; i < 8; i++) begin
      w_lane[i] = xgmii_txd[8*i +: 8];
      {w_mapped[i], w_cc[i]} = mapCtrl(w_lane[i]);
    end
  end

  // Anything that does not match a legal block layout falls through to the error block.
  always_comb begin
    w_encData = ERR_BLOCK;
    w_encHdr  = HDR_CTRL;
    w_bad     = 1'b1;
    w_isStart = 1'b0;
    w_isTerm  = 1'b0;
    w_gtMask  = '0;
    if (xgmii_txc == 8'h00) begin
      w_encData = xgmii_txd;
      w_encHdr  = HDR_DATA;
      w_bad     = 1'b0;
    end else if (xgmii_txc == 8'hff && (&w_mapped)) begin
      w_encData = {w_cc[7], w_cc[6], w_cc[5], w_cc[4], w_cc[3], w_cc[2], w_cc[1], w_cc[0], 8'h1e};
      w_bad     = 1'b0;
    end else if (xgmii_txc == 8'h01 && w_lane[0] == 8'hfb) begin
      w_encData = {xgmii_txd[63:8], 8'h78};
      w_bad     = 1'b0;
      w_isStart = 1'b1;
    end else if (xgmii_txc == 8'h1f && w_lane[4] == 8'hfb && (&w_mapped[3:0])) begin
      w_encData = {xgmii_txd[63:40], 4'h0, w_cc[3], w_cc[2], w_cc[1], w_cc[0], 8'h33};
      w_bad     = 1'b0;
      w_isStart = 1'b1;
    end else if (xgmii_txc == 8'h11 && w_lane[0] == 8'h9c && w_lane[4] == 8'hfb) begin
      w_encData = {xgmii_txd[63:40], 4'h0, O_SEQ, xgmii_txd[31:8], 8'h66};
      w_bad     = 1'b0;
      w_isStart = 1'b1;
    end else if (xgmii_txc == 8'h11 && w_lane[0] == 8'h9c && w_lane[4] == 8'h9c) begin
      w_encData = {xgmii_txd[63:40], O_SEQ, O_SEQ, xgmii_txd[31:8], 8'h55};
      w_bad     = 1'b0;
    end else if (xgmii_txc == 8'hf1 && w_lane[0] == 8'h9c && (&w_mapped[7:4])) begin
      w_encData = {w_cc[7], w_cc[6], w_cc[5], w_cc[4], O_SEQ, xgmii_txd[31:8], 8'h4b};
      w_bad     = 1'b0;
    end else if (xgmii_txc == 8'h1f && w_lane[4] == 8'h9c && (&w_mapped[3:0])) begin
      w_encData = {xgmii_txd[63:40], O_SEQ, w_cc[3], w_cc[2], w_cc[1], w_cc[0], 8'h2d};
      w_bad     = 1'b0;
    end else begin
      // Terminate in lane k: k data lanes below it, encodable control characters above it.
      for (int k = 0; k < 8; k++) begin
        w_gtMask = 8'hfe << k;
        if (xgmii_txc == (8'hff << k) && w_lane[k] == 8'hfd &&
            ((w_mapped & w_gtMask) == w_gtMask)) begin
          w_encData      = '0;
          w_encData[7:0] = termType(k);
          for (int j = 0; j < 8; j++) begin
            if (j < k) begin
              w_encData[8+8*j +: 8] = w_lane[j];
            end else if (j > k) begin
              w_encData[7*j+8 +: 7] = w_cc[j];
            end
          end
          w_bad    = 1'b0;
          w_isTerm = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_isStart) begin
      w_nextState = ST_FRAME;
    end else if (w_isTerm) begin
      w_nextState = ST_IDLE;
    end
  end

  always_comb begin
    w_seqErr = 1'b0;
    if (w_isStart && r_state == ST_FRAME) begin
      w_seqErr = 1'b1;
    end else if (w_isTerm && r_state == ST_IDLE) begin
      w_seqErr = 1'b1;
    end
  end

  // While the gearbox withholds a word the block and header hold; only the valids drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= IDLE_BLK;
      r_hdr       <= HDR_CTRL;
      r_dataValid <= 1'b0;
      r_hdrValid  <= 1'b0;
      r_bad       <= 1'b0;
      r_seqErr    <= 1'b0;
    end else if (w_accept) begin
      r_data      <= w_encData;
      r_hdr       <= w_encHdr;
      r_dataValid <= 1'b1;
      r_hdrValid  <= 1'b1;
      r_bad       <= w_bad;
      r_seqErr    <= w_seqErr;
    end else begin
      r_dataValid <= 1'b0;
      r_hdrValid  <= 1'b0;
      r_bad       <= 1'b0;
      r_seqErr    <= 1'b0;
    end
  end

  assign encoded_tx_data       = r_data;
  assign encoded_tx_hdr        = r_hdr;
  assign encoded_tx_data_valid = GBX_IF_EN ? r_dataValid : 1'b1;
  assign encoded_tx_hdr_valid  = GBX_IF_EN ? r_hdrValid : 1'b1;
  assign tx_bad_block          = r_bad;
  assign tx_sequence_error     = r_seqErr;

endmodule

// File: tb/tb_taxi_xgmii_baser_enc_64.sv
// Directed bench for the 64b/66b encoder: a vector table for single-word encodings
// plus hand sequences for reset, frame tracking and gearbox valid handling.
module tb_taxi_xgmii_baser_enc_64;

  localparam logic [63:0] ERR_BLK  = {{8{7'h1e}}, 8'h1e};
  localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001e;
  localparam logic [63:0] START_TXD = 64'hd555_5555_5555_55fb;
  localparam logic [63:0] START_BLK = 64'hd555_5555_5555_5578;
  localparam logic [63:0] TERM0_TXD = 64'h0707_0707_0707_07fd;
  localparam logic [63:0] TERM0_BLK = 64'h0000_0000_0000_0087;

  typedef struct {
    string       name;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [63:0] expData;
    logic [1:0]  expHdr;
    logic        expBad;
    logic        expSeq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        txValid;

  logic [63:0] data0, dataG;
  logic [1:0]  hdr0, hdrG;
  logic        dValid0, hValid0, dValidG, hValidG;
  logic        bad0, badG, seq0, seqG;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  taxi_xgmii_baser_enc_64 #(.GBX_IF_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .xgmii_txd(txd), .xgmii_txc(txc), .xgmii_tx_valid(txValid),
    .encoded_tx_data(data0), .encoded_tx_data_valid(dValid0),
    .encoded_tx_hdr(hdr0), .encoded_tx_hdr_valid(hValid0),
    .tx_bad_block(bad0), .tx_sequence_error(seq0)
  );

  taxi_xgmii_baser_enc_64 #(.GBX_IF_EN(1'b1)) dutGbx (
    .clk(clk), .rst(rst), .xgmii_txd(txd), .xgmii_txc(txc), .xgmii_tx_valid(txValid),
    .encoded_tx_data(dataG), .encoded_tx_data_valid(dValidG),
    .encoded_tx_hdr(hdrG), .encoded_tx_hdr_valid(hValidG),
    .tx_bad_block(badG), .tx_sequence_error(seqG)
  );

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c, input logic v);
    @(negedge clk);
    txd = d;
    txc = c;
    txValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] expData, input logic [1:0] expHdr,
                             input logic expBad, input logic expSeq);
    checkField({name, " data"}, data0, expData);
    checkField({name, " hdr"}, {62'd0, hdr0}, {62'd0, expHdr});
    checkField({name, " bad"}, {63'd0, bad0}, {63'd0, expBad});
    checkField({name, " seqerr"}, {63'd0, seq0}, {63'd0, expSeq});
  endtask

  task automatic checkGbx(input string name, input logic expValid, input logic [63:0] expData,
                          input logic expBad, input logic expSeq);
    checkField({name, " gbx dvalid"}, {63'd0, dValidG}, {63'd0, expValid});
    checkField({name, " gbx hvalid"}, {63'd0, hValidG}, {63'd0, expValid});
    checkField({name, " gbx data"}, dataG, expData);
    checkField({name, " gbx bad"}, {63'd0, badG}, {63'd0, expBad});
    checkField({name, " gbx seqerr"}, {63'd0, seqG}, {63'd0, expSeq});
  endtask

  initial begin
    rst = 1'b1;
    txd = 64'h0707_0707_0707_0707;
    txc = 8'hff;
    txValid = 1'b1;

    // Frame state carries from row to row, so the expected sequence errors depend on order.
    vecs.push_back('{"idle", 64'h0707_0707_0707_0707, 8'hff, IDLE_BLK, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"start78", START_TXD, 8'h01, START_BLK, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"data", 64'h0123_4567_89ab_cdef, 8'h00, 64'h0123_4567_89ab_cdef, 2'b10, 1'b0, 1'b0});
    vecs.push_back('{"term3", 64'h0707_0707_fdaa_bbcc, 8'hf8, 64'h0000_0000_aabb_ccb4, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"badlane", 64'h0707_0707_0755_0707, 8'hff, ERR_BLK, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{"idle2", 64'h0707_0707_0707_0707, 8'hff, IDLE_BLK, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"term0nofrm", TERM0_TXD, 8'hff, TERM0_BLK, 2'b01, 1'b0, 1'b1});
    vecs.push_back('{"start33", 64'h1122_33fb_0707_0707, 8'h1f, 64'h1122_3300_0000_0033, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"start78dup", 64'h0706_0504_0302_01fb, 8'h01, 64'h0706_0504_0302_0178, 2'b01, 1'b0, 1'b1});
    vecs.push_back('{"term7", 64'hfd66_5544_3322_1100, 8'h80, 64'h6655_4433_2211_00ff, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"os4b", 64'h3c1c_fe07_ccbb_aa9c, 8'hf1, 64'h66b4_f000_ccbb_aa4b, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"os2d", 64'h0a0b_0c9c_0707_0707, 8'h1f, 64'h0a0b_0c00_0000_002d, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"start66", 64'h3322_11fb_ccbb_aa9c, 8'h11, 64'h3322_1100_ccbb_aa66, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"os55", 64'h6655_449c_3322_119c, 8'h11, 64'h6655_4400_3322_1155, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"nofb", 64'h1111_1111_1111_1107, 8'h01, ERR_BLK, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{"term1", 64'h0707_0707_0707_fd5a, 8'hfe, 64'h0000_0000_0000_5a99, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{"term2bad", 64'h0707_0707_55fd_2211, 8'hfc, ERR_BLK, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{"idlemix", 64'hf7dc_bc7c_3c1c_fe06, 8'hff,
                     {7'h78, 7'h66, 7'h55, 7'h4b, 7'h33, 7'h2d, 7'h1e, 7'h06, 8'h1e}, 2'b01, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", IDLE_BLK, 2'b01, 1'b0, 1'b0);
    checkField("reset dvalid", {63'd0, dValid0}, 64'd1);
    checkField("reset hvalid", {63'd0, hValid0}, 64'd1);
    checkField("reset gbx dvalid", {63'd0, dValidG}, 64'd0);
    checkField("reset gbx hvalid", {63'd0, hValidG}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].txd, vecs[i].txc, 1'b1);
      checkOutput(vecs[i].name, vecs[i].expData, vecs[i].expHdr, vecs[i].expBad, vecs[i].expSeq);
    end

    // Reset between Start and Terminate leaves the Terminate orphaned.
    applyStimulus(START_TXD, 8'h01, 1'b1);
    checkOutput("midrst start", START_BLK, 2'b01, 1'b0, 1'b0);
    pulseReset();
    checkOutput("midrst reset", IDLE_BLK, 2'b01, 1'b0, 1'b0);
    applyStimulus(TERM0_TXD, 8'hff, 1'b1);
    checkOutput("midrst term", TERM0_BLK, 2'b01, 1'b0, 1'b1);

    // Gearbox valid toggles; the non-gearbox instance must ignore the valid input.
    pulseReset();
    applyStimulus(START_TXD, 8'h01, 1'b1);
    checkGbx("v1 start", 1'b1, START_BLK, 1'b0, 1'b0);
    applyStimulus(TERM0_TXD, 8'hff, 1'b0);
    checkGbx("v0 term", 1'b0, START_BLK, 1'b0, 1'b0);
    checkOutput("nogbx term", TERM0_BLK, 2'b01, 1'b0, 1'b0);
    applyStimulus(64'h0707_0707_0755_0707, 8'hff, 1'b0);
    checkGbx("v0 bad", 1'b0, START_BLK, 1'b0, 1'b0);
    checkOutput("nogbx bad", ERR_BLK, 2'b01, 1'b1, 1'b0);
    applyStimulus(TERM0_TXD, 8'hff, 1'b1);
    checkGbx("v1 term", 1'b1, TERM0_BLK, 1'b0, 1'b0);
    checkOutput("nogbx term2", TERM0_BLK, 2'b01, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
